// File: rtl/comparator_sweep_checker.sv
// comparator_sweep_checker
// On-chip exhaustive checker for a WIDTH-bit magnitude comparator. It walks
// every (A, B) operand pair with A as the outer loop and B as the inner loop.
// Each pair is held for SETTLE cycles, and then for one check cycle. The flags
// returned by the comparator are compared against a built-in golden model.
// The checker reports an error count, the first failing pair and a pass flag.
// SETTLE must be at least 1.
module comparator_sweep_checker #(
    parameter int WIDTH  = 2,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   A,
    output logic [WIDTH-1:0]   B,
    input  logic               A_gt_B,
    input  logic               A_eq_B,
    input  logic               A_lt_B,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic               fail_valid,
    output logic [WIDTH-1:0]   fail_A,
    output logic [WIDTH-1:0]   fail_B
);

    // The error count reaches at most 2^(2*WIDTH), which fits in 2*WIDTH+1
    // bits, so it never needs to saturate.
    localparam int ERR_W = 2*WIDTH + 1;
    // The settle counter runs from 0 to SETTLE-1 while the state is DRIVE.
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [WIDTH-1:0] OPND_MAX    = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_settle_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [ERR_W-1:0]   r_err_count;
    logic               r_fail_valid;
    logic [WIDTH-1:0]   r_fail_a;
    logic [WIDTH-1:0]   r_fail_b;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;

    logic               w_sweep_start;
    logic               w_check;
    logic               w_last_pair;
    logic [2:0]         w_observed;
    logic [2:0]         w_expected;
    logic               w_pair_fail;
    logic [ERR_W-1:0]   w_err_next;

    // Reference comparator: unsigned {gt, eq, lt}, which is always one-hot.
    function automatic logic [2:0] golden_flags(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        return {(a > b), (a == b), (a < b)};
    endfunction

    // Any difference from the model counts as a failure. This also covers
    // flag patterns that are all-zero or have more than one bit high.
    assign w_last_pair = (r_a == OPND_MAX) && (r_b == OPND_MAX);
    assign w_observed  = {A_gt_B, A_eq_B, A_lt_B};
    assign w_expected  = golden_flags(r_a, r_b);
    assign w_pair_fail = w_check && (w_observed != w_expected);
    assign w_err_next  = r_err_count + ERR_W'(w_pair_fail);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. Each pair is held in DRIVE and then checked in CHECK.
    // start is only recognised in IDLE and in DONE.
    always_comb begin
        w_state_next  = r_state;
        w_sweep_start = 1'b0;
        w_check       = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_next  = S_DRIVE;
                    w_sweep_start = 1'b1;
                end
            end
            S_DRIVE: begin
                if (r_settle_cnt == SETTLE_LAST) begin
                    w_state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                w_check = 1'b1;
                if (w_last_pair) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_DRIVE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Settle counter. It counts cycles spent in DRIVE and restarts from 0 on
    // every entry into DRIVE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_settle_cnt <= '0;
        end else if ((r_state == S_DRIVE) && (w_state_next == S_DRIVE)) begin
            r_settle_cnt <= r_settle_cnt + CNT_W'(1);
        end else begin
            r_settle_cnt <= '0;
        end
    end

    // Operand sweep. B is the inner loop and A advances when B wraps. Both
    // hold at (max, max) once the last pair has been checked.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a <= '0;
            r_b <= '0;
        end else if (w_sweep_start) begin
            r_a <= '0;
            r_b <= '0;
        end else if (w_check && !w_last_pair) begin
            r_b <= r_b + WIDTH'(1);
            if (r_b == OPND_MAX) begin
                r_a <= r_a + WIDTH'(1);
            end
        end
    end

    // Error accounting. Only the first failing pair is captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count  <= '0;
            r_fail_valid <= 1'b0;
            r_fail_a     <= '0;
            r_fail_b     <= '0;
        end else if (w_sweep_start) begin
            r_err_count  <= '0;
            r_fail_valid <= 1'b0;
            r_fail_a     <= '0;
            r_fail_b     <= '0;
        end else if (w_check) begin
            r_err_count <= w_err_next;
            if (w_pair_fail && !r_fail_valid) begin
                r_fail_valid <= 1'b1;
                r_fail_a     <= r_a;
                r_fail_b     <= r_b;
            end
        end
    end

    // Sweep status. pass uses the count that includes the final check.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_pass <= 1'b0;
        end else if (w_sweep_start) begin
            r_busy <= 1'b1;
            r_done <= 1'b0;
            r_pass <= 1'b0;
        end else if (w_check && w_last_pair) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_pass <= (w_err_next == '0);
        end
    end

    assign A          = r_a;
    assign B          = r_b;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_count  = r_err_count;
    assign fail_valid = r_fail_valid;
    assign fail_A     = r_fail_a;
    assign fail_B     = r_fail_b;

endmodule

// File: doc/comparator_sweep_checker.md
# comparator_sweep_checker

Self-checking exhaustive stimulus/response engine for the magnitude comparator. On `start`, it drives every (A, B) operand pair into the comparator, with A as the outer loop and B as the inner loop. It waits a programmable settle time for each pair, samples the three comparator flags and checks them against an internal golden model. It reports an error count, the first failing pair and a pass flag. The block sits opposite the comparator: it drives the comparator's inputs and consumes its outputs, replacing the software testbench loop with synthesizable logic usable on-chip (BIST).

## Interface
- `WIDTH`, default 2: operand width; must match the comparator under check.
- `SETTLE`, default 1: cycles each pair is held before sampling. Minimum 1; 0 is illegal.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a sweep. Sampled only in IDLE or DONE.
- `A`  out  WIDTH  operand A to the comparator.
- `B`  out  WIDTH  operand B to the comparator.
- `A_gt_B`  in  1  comparator flag under check.
- `A_eq_B`  in  1  comparator flag under check.
- `A_lt_B`  in  1  comparator flag under check.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  high in DONE until the next start or reset.
- `pass`  out  1  high in DONE when `err_count` is 0; low otherwise.
- `err_count`  out  2*WIDTH+1  number of failing pairs in the current or last sweep.
- `fail_valid`  out  1  a failure has been captured.
- `fail_A`  out  WIDTH  A of the first failing pair.
- `fail_B`  out  WIDTH  B of the first failing pair.

## Operation
- **Reset values.** On `rst`, all outputs go to 0 and the state goes to IDLE. `rst` overrides everything, including a sweep in progress; no partial results are retained.
- **States.**
  - IDLE: on `start`, go to DRIVE.
  - DRIVE: count SETTLE cycles, then go to CHECK.
  - CHECK: spend one cycle, then go to DRIVE for the next pair, or to DONE after the last pair.
  - DONE: on `start`, go to DRIVE.
- **Sweep start (IDLE/DONE → DRIVE).** At this edge:
  - A and B are set to 0; `busy` is set to 1; `done` and `pass` are cleared.
  - `err_count`, `fail_valid`, `fail_A` and `fail_B` are cleared.
- **Golden model.**
  - gt is 1 when A > B, eq is 1 when A == B, lt is 1 when A < B, using unsigned compare.
  - A pair fails if any of the three flags differs from the model. This includes multiple-hot and all-zero flag patterns.
  - A failing pair increments `err_count` by 1.
- **Error count range.** The maximum is 2^(2*WIDTH), which fits in 2*WIDTH+1 bits, so no saturation is needed.
- **First-failure capture.** On the first failure, `fail_A`/`fail_B` take the current A/B and `fail_valid` is set. Later failures do not overwrite them.
- **Sweep order.** B increments after each CHECK. When B wraps from 2^WIDTH−1 to 0, A increments. The order is (0,0), (0,1) … (0,max), (1,0) … (max,max).
- **Sweep end.** After the CHECK of (max,max), the state goes to DONE:
  - `busy` goes to 0 and `done` to 1.
  - `pass` is set to 1 if `err_count` is 0 after the final check.
  - A and B hold at (max,max).
- **`start` handling.**
  - `start` asserted during DRIVE or CHECK is ignored, with no restart and no side effects.
  - `start` in DONE begins a fresh sweep.
  - A level-held `start` in DONE restarts the sweep each time DONE is reached. This is legal.

## Timing
- Each pair occupies SETTLE+1 cycles: SETTLE cycles in DRIVE plus 1 in CHECK.
- The comparator flags are sampled at the rising edge ending the CHECK cycle.
- A and B change only on the edge leaving CHECK, or on the edge taking IDLE/DONE to DRIVE.
- `done` rises 2^(2*WIDTH)·(SETTLE+1) edges after the edge that sampled `start`. With the defaults this is 32 edges.
- `err_count` and `fail_*` update on the CHECK-ending edge and are stable from then on.
- `pass` is valid only while `done` is 1.
- The comparator under check must settle its outputs within SETTLE cycles, from A/B registered outputs, with no latency to its inputs.

## Test plan
- **Golden comparator, defaults.** Pulse `start` → `busy`=1 for 32 cycles. At DONE: `done`=1, `pass`=1, `err_count`=0, `fail_valid`=0, A=B=3.
- **Stuck A_eq_B=1 (gt/lt correct), defaults.**
  - Expected at DONE: `err_count`=12, `pass`=0, `fail_valid`=1, `fail_A`=0, `fail_B`=1.
- **gt/lt swapped model.**
  - Expected at DONE: `err_count`=12, `fail_A`=0, `fail_B`=1.
  - Then pulse `start` again: verify `err_count` is cleared at the start edge and returns to 12.
- **Reset mid-operation.**
  - Assert `rst` while on pair (1,1). Next cycle: all outputs are 0 and the state is IDLE.
  - Then pulse `start` → a full sweep completes in 32 cycles with correct results.
- **`start` during busy.**
  - Pulse `start` at cycles 5 and 20 of a sweep → no restart; `done` still rises 32 edges after the original start.
- **Settle parameter.** Set SETTLE=3 with a comparator model that has 2 cycles of output delay:
  - Expected: `pass`=1, with `done` at 64 edges.
  - With SETTLE=1 and the same delayed model: `pass`=0 and `err_count`>0.
